// File: rtl/bus_arb_pkg.sv
// Shared bus arbitration types and default sizing used by the scheduler and master models.
package bus_arb_pkg;

  localparam int unsigned DEF_N_REQ    = 8;
  localparam int unsigned DEF_MAX_HOLD = 16;
  localparam int unsigned DEF_CNT_W    = 32;

  // Scheduler state: IDLE has no grant, GRANT has exactly one grant bit set
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of vec searching upward from last_ptr+1 with wrap.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         vec,
  input  logic [$clog2(N_REQ)-1:0] last_ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] cand;

  // Walk the rotated order; the previous winner is examined last
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(last_ptr) + k) % N_REQ);
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_bus_scheduler.sv
// Round-robin bus scheduler: one registered one-hot grant, revoked on release,
// mask or hold-time limit, always followed by at least one idle cycle.
module rr_bus_scheduler
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         cfg_mask,
  output logic [N_REQ-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     timeout_pulse,
  output logic [CNT_W-1:0]         grant_count
);

  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  state_e            state;
  logic [ID_W-1:0]   last_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_REQ-1:0]  eff_req;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;

  // Only enabled requesters take part in arbitration and ownership
  assign eff_req = req & cfg_mask;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .vec      (eff_req),
    .last_ptr (last_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Scheduler FSM with hold counter, fairness pointer, grant counter and timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      owner_id      <= '0;
      timeout_pulse <= 1'b0;
      grant_count   <= '0;
      hold_cnt      <= '0;
      last_ptr      <= ID_W'(N_REQ - 1);
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant       <= N_REQ'(1) << pick_idx;
            grant_valid <= 1'b1;
            owner_id    <= pick_idx;
            last_ptr    <= pick_idx;
            hold_cnt    <= '0;
            grant_count <= grant_count + CNT_W'(1);
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!eff_req[owner_id]) begin
            // Release or mask wins over the hold limit, no pulse
            grant       <= '0;
            grant_valid <= 1'b0;
            owner_id    <= '0;
            state       <= ST_IDLE;
          end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
            grant         <= '0;
            grant_valid   <= 1'b0;
            owner_id      <= '0;
            timeout_pulse <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          grant       <= '0;
          grant_valid <= 1'b0;
          owner_id    <= '0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Directed bench for rr_bus_scheduler: instance a (MAX_HOLD=16, 32-bit count)
// and instance b (MAX_HOLD=4, 4-bit count) share clock and reset.
module tb_rr_bus_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] req_a, mask_a, grant_a;
  logic [7:0] req_b, mask_b, grant_b;
  logic       valid_a, valid_b, pulse_a, pulse_b;
  logic [2:0] owner_a, owner_b;
  logic [31:0] count_a;
  logic [3:0]  count_b;

  logic [7:0] eff_prev_a, eff_prev_b, gnt_prev_a, gnt_prev_b;

  int n_checks = 0;
  int n_errors = 0;

  rr_bus_scheduler #(.N_REQ(8), .MAX_HOLD(16), .CNT_W(32)) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .req           (req_a),
    .cfg_mask      (mask_a),
    .grant         (grant_a),
    .grant_valid   (valid_a),
    .owner_id      (owner_a),
    .timeout_pulse (pulse_a),
    .grant_count   (count_a)
  );

  rr_bus_scheduler #(.N_REQ(8), .MAX_HOLD(4), .CNT_W(4)) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .req           (req_b),
    .cfg_mask      (mask_b),
    .grant         (grant_b),
    .grant_valid   (valid_b),
    .owner_id      (owner_b),
    .timeout_pulse (pulse_b),
    .grant_count   (count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture what each scheduler saw at the edge, for the per-cycle properties
  always @(posedge clk) begin
    eff_prev_a <= req_a & mask_a;
    eff_prev_b <= req_b & mask_b;
    gnt_prev_a <= grant_a;
    gnt_prev_b <= grant_b;
  end

  // Per-cycle properties: one-hot grant, only to a live request, no direct handoff
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot_a", 32'($onehot0(grant_a)), 32'd1);
      check("onehot_b", 32'($onehot0(grant_b)), 32'd1);
      check("eff_a", 32'(grant_a & ~eff_prev_a), 32'd0);
      check("eff_b", 32'(grant_b & ~eff_prev_b), 32'd0);
      check("handoff_a", 32'(gnt_prev_a != 8'd0 && grant_a != 8'd0 && grant_a != gnt_prev_a), 32'd0);
      check("handoff_b", 32'(gnt_prev_b != 8'd0 && grant_b != 8'd0 && grant_b != gnt_prev_b), 32'd0);
    end
  end

  initial begin
    rst    = 1'b1;
    req_a  = 8'h00;
    req_b  = 8'h00;
    mask_a = 8'hFF;
    mask_b = 8'hFF;

    // Reset held for three cycles under random requests
    for (int i = 0; i < 3; i++) begin
      req_a = 8'($urandom);
      req_b = 8'($urandom);
      tick();
      check("rst_grant_a", 32'(grant_a), 32'd0);
      check("rst_valid_a", 32'(valid_a), 32'd0);
      check("rst_count_a", count_a, 32'd0);
      check("rst_pulse_a", 32'(pulse_a), 32'd0);
      check("rst_grant_b", 32'(grant_b), 32'd0);
      check("rst_owner_b", 32'(owner_b), 32'd0);
    end
    rst   = 1'b0;
    req_a = 8'h00;
    req_b = 8'h00;
    tick();
    check("idle_grant_a", 32'(grant_a), 32'd0);

    // Single requester 3 holds for five cycles then releases
    req_a = 8'h08;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold3_grant", 32'(grant_a), 32'h08);
      check("hold3_owner", 32'(owner_a), 32'd3);
      check("hold3_valid", 32'(valid_a), 32'd1);
    end
    req_a = 8'h00;
    tick();
    check("rel3_grant", 32'(grant_a), 32'd0);
    check("rel3_valid", 32'(valid_a), 32'd0);
    check("rel3_pulse", 32'(pulse_a), 32'd0);
    check("rel3_count", count_a, 32'd1);

    // Last owner 3: requests 2 and 5 together, 5 wins, then 2
    req_a = 8'h24;
    tick();
    check("rr25_first", 32'(grant_a), 32'h20);
    check("rr25_owner", 32'(owner_a), 32'd5);
    req_a = 8'h04;
    tick();
    check("rr25_gap", 32'(grant_a), 32'd0);
    check("rr25_gap_owner", 32'(owner_a), 32'd0);
    tick();
    check("rr25_second", 32'(grant_a), 32'h04);
    check("rr25_owner2", 32'(owner_a), 32'd2);
    req_a = 8'h00;
    tick();
    check("rr25_count", count_a, 32'd3);

    // Owner 6 masked mid-grant: immediate revoke, no pulse, then ignored
    req_a = 8'h40;
    tick();
    check("mask_grant", 32'(grant_a), 32'h40);
    tick();
    check("mask_grant2", 32'(grant_a), 32'h40);
    mask_a = 8'hBF;
    tick();
    check("mask_revoke", 32'(grant_a), 32'd0);
    check("mask_pulse", 32'(pulse_a), 32'd0);
    check("mask_owner", 32'(owner_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mask_ignored", 32'(grant_a), 32'd0);
    end
    req_a  = 8'h00;
    mask_a = 8'hFF;
    tick();
    check("mask_count", count_a, 32'd4);

    // All requesting, MAX_HOLD=4: owners 0..7,0 with 4 grant + 1 idle cycle each
    req_b = 8'hFF;
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check("rr_grant", 32'(grant_b), 32'(8'd1 << (r % 8)));
        check("rr_owner", 32'(owner_b), 32'(r % 8));
        check("rr_nopulse", 32'(pulse_b), 32'd0);
      end
      tick();
      check("rr_idle", 32'(grant_b), 32'd0);
      check("rr_to_pulse", 32'(pulse_b), 32'd1);
    end
    req_b = 8'h00;
    tick();
    check("rr_pulse_once", 32'(pulse_b), 32'd0);
    check("rr_grant_off", 32'(grant_b), 32'd0);
    check("rr_count", 32'(count_b), 32'd9);

    // Release on the same edge as the hold limit: release wins, no pulse
    req_b = 8'h10;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("lim_grant", 32'(grant_b), 32'h10);
    end
    req_b = 8'h00;
    tick();
    check("lim_grant_off", 32'(grant_b), 32'd0);
    check("lim_pulse", 32'(pulse_b), 32'd0);
    check("lim_count", 32'(count_b), 32'd10);

    // Counter wrap with a 4-bit grant_count: 17 one-cycle grants read as 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrap_count0", 32'(count_b), 32'd0);
    for (int i = 0; i < 17; i++) begin
      req_b = 8'h01;
      tick();
      check("wrap_grant", 32'(grant_b), 32'h01);
      req_b = 8'h00;
      tick();
    end
    check("wrap_count", 32'(count_b), 32'd1);

    // Reset mid-grant: grant drops at the reset edge and index 0 wins next
    req_b = 8'h80;
    tick();
    check("rstmid_grant", 32'(grant_b), 32'h80);
    rst   = 1'b1;
    req_b = 8'hFF;
    tick();
    check("rstmid_off", 32'(grant_b), 32'd0);
    check("rstmid_valid", 32'(valid_b), 32'd0);
    check("rstmid_count", 32'(count_b), 32'd0);
    rst = 1'b0;
    tick();
    check("rstmid_first", 32'(grant_b), 32'h01);
    check("rstmid_owner", 32'(owner_b), 32'd0);
    check("rstmid_valid1", 32'(valid_b), 32'd1);
    check("rstmid_count1", 32'(count_b), 32'd1);
    req_b = 8'h00;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
